// File: rtl/sonic_vc_rl_tx_adapter.sv
// Avalon-ST ready-latency adapter: RL0 source to RL-N sink, one-cycle registered path.
// A framing checker marks beats that break SOP/EOP ordering on out_error and framing_err.
module sonic_vc_rl_tx_adapter #(
  parameter int DATA_WIDTH    = 128,
  parameter int EMPTY_WIDTH   = 2,
  parameter int READY_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  output logic                   in_ready,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_error,
  input  logic                   in_startofpacket,
  input  logic                   in_endofpacket,
  input  logic [EMPTY_WIDTH-1:0] in_empty,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_error,
  output logic                   out_startofpacket,
  output logic                   out_endofpacket,
  output logic [EMPTY_WIDTH-1:0] out_empty,
  output logic                   framing_err
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } frame_state_t;

  frame_state_t frame_state_r;
  logic         grant_s;
  logic         accept_s;
  logic         malformed_s;

  // A beat is malformed when SOP arrives inside a packet or is missing outside one.
  function automatic logic beat_malformed(input frame_state_t st, input logic sop);
    logic bad;
    case (st)
      ST_IDLE:   bad = ~sop;
      ST_IN_PKT: bad = sop;
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

  generate
    if (READY_LATENCY == 1) begin : g_rl1
      assign grant_s = out_ready;
    end else begin : g_rln
      logic [READY_LATENCY-2:0] rdy_pipe;

      // Delay out_ready by N-1 cycles so acceptance lands N cycles after the sink's ready.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          rdy_pipe <= '0;
        end else begin
          rdy_pipe[0] <= out_ready;
          for (int i = 1; i < READY_LATENCY - 1; i++) begin
            rdy_pipe[i] <= rdy_pipe[i-1];
          end
        end
      end

      assign grant_s = rdy_pipe[READY_LATENCY-2];
    end
  endgenerate

  assign in_ready = grant_s;

  // Acceptance and framing verdict for the beat presented this cycle.
  always_comb begin
    accept_s    = 1'b0;
    malformed_s = 1'b0;
    if (in_valid && grant_s) begin
      accept_s    = 1'b1;
      malformed_s = beat_malformed(frame_state_r, in_startofpacket);
    end else begin
      accept_s    = 1'b0;
      malformed_s = 1'b0;
    end
  end

  // Framing state and output registers; payload holds when nothing is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_state_r     <= ST_IDLE;
      out_valid         <= 1'b0;
      out_data          <= '0;
      out_error         <= 1'b0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      out_empty         <= '0;
      framing_err       <= 1'b0;
    end else begin
      out_valid   <= accept_s;
      framing_err <= accept_s & malformed_s;
      if (accept_s) begin
        out_data          <= in_data;
        out_error         <= in_error | malformed_s;
        out_startofpacket <= in_startofpacket;
        out_endofpacket   <= in_endofpacket;
        out_empty         <= in_empty;
        // Every transition, flagged or not, resolves to IDLE on EOP and IN_PKT otherwise.
        frame_state_r     <= in_endofpacket ? ST_IDLE : ST_IN_PKT;
      end
    end
  end

endmodule

// File: tb/tb_sonic_vc_rl_tx_adapter.sv
// Bench for sonic_vc_rl_tx_adapter: three instances (N=1,2,3) share stimulus and are
// checked every cycle against a history-based model, plus literal expectations per scenario.
module tb_sonic_vc_rl_tx_adapter;
  localparam int DW = 128;
  localparam int EW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, in_valid, in_error, in_sop, in_eop, out_ready;
  logic [DW-1:0] in_data;
  logic [EW-1:0] in_empty;
  logic ir [3], ov [3], oerr [3], osop [3], oeop [3], fe [3];
  logic [DW-1:0] od [3];
  logic [EW-1:0] oem [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sonic_vc_rl_tx_adapter #(.DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .READY_LATENCY(g + 1)) dut (
      .clk(clk), .reset_n(reset_n), .in_ready(ir[g]), .in_valid(in_valid), .in_data(in_data),
      .in_error(in_error), .in_startofpacket(in_sop), .in_endofpacket(in_eop), .in_empty(in_empty),
      .out_ready(out_ready), .out_valid(ov[g]), .out_data(od[g]), .out_error(oerr[g]),
      .out_startofpacket(osop[g]), .out_endofpacket(oeop[g]), .out_empty(oem[g]),
      .framing_err(fe[g]));
  end

  // Model state: instance d has ready latency d+1.
  bit m_valid [3], m_err [3], m_sop [3], m_eop [3], m_ferr [3], m_open [3];
  logic [DW-1:0] m_data [3];
  logic [EW-1:0] m_empty [3];
  bit rlog [$];
  int last_rst;
  int n_cmp, n_bad;
  typedef struct {
    int cyc;
    logic [DW-1:0] data;
    bit sop, eop, err, ferr;
  } beat_t;
  beat_t blog [$];
  int log_dut;
  bit snap_ir [3];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Grant in cycle c for latency d+1: out_ready from d cycles ago, unless reset intervened.
  function automatic bit grant_of(input int d, input int c);
    int j;
    if (d == 0) return rlog[c];
    if (reset_n !== 1'b1) return 1'b0;
    j = c - d;
    if (j <= last_rst) return 1'b0;
    return rlog[j];
  endfunction

  task automatic step(input bit rst, input bit iv, input logic [DW-1:0] data, input bit sop,
                      input bit eop, input bit err, input logic [EW-1:0] emp, input bit ordy,
                      input bit rst_mid);
    int c;
    bit acc, flagged, prior;
    @(negedge clk);
    reset_n = rst; in_valid = iv; in_data = data; in_sop = sop; in_eop = eop;
    in_error = err; in_empty = emp; out_ready = ordy;
    rlog.push_back(ordy);
    c = rlog.size() - 1;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk1($sformatf("in_ready[N=%0d] c%0d", d + 1, c), ir[d], grant_of(d, c));
      snap_ir[d] = ir[d];
      chk1($sformatf("out_valid[N=%0d] c%0d", d + 1, c), ov[d], m_valid[d]);
      chkw($sformatf("out_data[N=%0d] c%0d", d + 1, c), od[d], m_data[d]);
      chk1($sformatf("out_error[N=%0d] c%0d", d + 1, c), oerr[d], m_err[d]);
      chk1($sformatf("out_sop[N=%0d] c%0d", d + 1, c), osop[d], m_sop[d]);
      chk1($sformatf("out_eop[N=%0d] c%0d", d + 1, c), oeop[d], m_eop[d]);
      chkw($sformatf("out_empty[N=%0d] c%0d", d + 1, c), DW'(oem[d]), DW'(m_empty[d]));
      chk1($sformatf("framing_err[N=%0d] c%0d", d + 1, c), fe[d], m_ferr[d]);
      if (ov[d] === 1'b1) begin
        prior = (c - d - 1 >= 0) ? rlog[c-d-1] : 1'b0;
        chk1($sformatf("ready_before_valid[N=%0d] c%0d", d + 1, c), prior, 1'b1);
      end
    end
    if (ov[log_dut] === 1'b1)
      blog.push_back('{c, od[log_dut], osop[log_dut], oeop[log_dut], oerr[log_dut], fe[log_dut]});
    if (rst_mid) begin
      reset_n = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) begin
        chk1($sformatf("rst_valid[N=%0d]", d + 1), ov[d], 1'b0);
        chkw($sformatf("rst_data[N=%0d]", d + 1), od[d], '0);
        chk1($sformatf("rst_err[N=%0d]", d + 1), oerr[d], 1'b0);
        chk1($sformatf("rst_sop[N=%0d]", d + 1), osop[d], 1'b0);
        chk1($sformatf("rst_eop[N=%0d]", d + 1), oeop[d], 1'b0);
        chkw($sformatf("rst_empty[N=%0d]", d + 1), DW'(oem[d]), '0);
        chk1($sformatf("rst_ferr[N=%0d]", d + 1), fe[d], 1'b0);
        chk1($sformatf("rst_in_ready[N=%0d]", d + 1), ir[d], (d == 0) ? out_ready : 1'b0);
      end
    end
    @(posedge clk);
    if (reset_n !== 1'b1) begin
      last_rst = c;
      for (int d = 0; d < 3; d++) begin
        m_valid[d] = 0; m_err[d] = 0; m_sop[d] = 0; m_eop[d] = 0; m_ferr[d] = 0;
        m_open[d] = 0; m_data[d] = '0; m_empty[d] = '0;
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        acc = in_valid && grant_of(d, c);
        m_valid[d] = acc;
        m_ferr[d] = 1'b0;
        if (acc) begin
          flagged = m_open[d] ? in_sop : !in_sop;
          m_data[d] = in_data; m_sop[d] = in_sop; m_eop[d] = in_eop; m_empty[d] = in_empty;
          m_err[d] = in_error | flagged;
          m_ferr[d] = flagged;
          m_open[d] = !in_eop;
        end
      end
    end
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, ordy, 1'b0);
  endtask

  task automatic beat(input logic [DW-1:0] data, input bit sop, input bit eop);
    step(1'b1, 1'b1, data, sop, eop, 1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic chk_log(input string name, input int k, input logic [DW-1:0] data,
                         input bit err, input bit ferr);
    if (blog.size() > k) begin
      chkw($sformatf("%s beat%0d data", name, k), blog[k].data, data);
      chk1($sformatf("%s beat%0d err", name, k), blog[k].err, err);
      chk1($sformatf("%s beat%0d ferr", name, k), blog[k].ferr, ferr);
    end else begin
      chki($sformatf("%s beat%0d present", name, k), blog.size(), k + 1);
    end
  endtask

  bit pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  bit exp_ir [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [DW-1:0] exp_t2 [4];
  int c0;

  initial begin
    n_cmp = 0; n_bad = 0; last_rst = -1; log_dut = 1;
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sop = 1'b0; in_eop = 1'b0;
    in_error = 1'b0; in_empty = '0; out_ready = 1'b0;
    for (int d = 0; d < 3; d++) begin m_data[d] = '0; m_empty[d] = '0; end

    // Reset with random inputs present.
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, DW'($urandom), 1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0);
    chk1("reset in_ready N=2", snap_ir[1], 1'b0);
    chk1("reset in_ready N=1", snap_ir[0], 1'b1);
    idle(4, 1'b1);

    // Scenario 1: 4-beat packet, N=2, out_ready held high.
    blog.delete();
    c0 = rlog.size();
    for (int i = 1; i <= 4; i++) beat(DW'(i), i == 1, i == 4);
    idle(2, 1'b1);
    chki("t1 beats", blog.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk_log("t1", k, DW'(k + 1), 1'b0, 1'b0);
      if (blog.size() > k) begin
        chki($sformatf("t1 beat%0d cycle", k), blog[k].cyc, c0 + k + 1);
        chk1($sformatf("t1 beat%0d sop", k), blog[k].sop, k == 0);
        chk1($sformatf("t1 beat%0d eop", k), blog[k].eop, k == 3);
      end
    end

    // Scenario 3: EOP-only beat from IDLE is flagged, next packet clean.
    blog.delete();
    beat(DW'(8'hA), 1'b0, 1'b1);
    idle(2, 1'b1);
    beat(DW'(8'hB), 1'b1, 1'b1);
    idle(2, 1'b1);
    chki("t3 beats", blog.size(), 2);
    chk_log("t3", 0, DW'(8'hA), 1'b1, 1'b1);
    chk_log("t3", 1, DW'(8'hB), 1'b0, 1'b0);

    // Scenario 4: repeated SOP on beat 2, then a clean single-beat packet.
    blog.delete();
    beat(DW'(8'h11), 1'b1, 1'b0);
    beat(DW'(8'h12), 1'b1, 1'b0);
    beat(DW'(8'h13), 1'b0, 1'b1);
    idle(1, 1'b1);
    beat(DW'(8'h14), 1'b1, 1'b1);
    idle(2, 1'b1);
    chki("t4 beats", blog.size(), 4);
    chk_log("t4", 0, DW'(8'h11), 1'b0, 1'b0);
    chk_log("t4", 1, DW'(8'h12), 1'b1, 1'b1);
    chk_log("t4", 2, DW'(8'h13), 1'b0, 1'b0);
    chk_log("t4", 3, DW'(8'h14), 1'b0, 1'b0);

    // Scenario 2: out_ready 1,0,1,1,0 with in_valid held, N=2.
    blog.delete();
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b1, DW'(8'h20 + k), 1'b1, 1'b1, 1'b0, '0, pat[k], 1'b0);
      chk1($sformatf("t2 in_ready k%0d", k), snap_ir[1], exp_ir[k]);
    end
    idle(3, 1'b0);
    exp_t2 = '{DW'(8'h20), DW'(8'h21), DW'(8'h23), DW'(8'h24)};
    chki("t2 beats", blog.size(), 4);
    for (int k = 0; k < 4; k++) chk_log("t2", k, exp_t2[k], 1'b0, 1'b0);
    idle(3, 1'b1);

    // Scenario 5: N=3, reset mid-packet while out_valid is high.
    log_dut = 2;
    blog.delete();
    beat(DW'(8'h31), 1'b1, 1'b0);
    step(1'b1, 1'b1, DW'(8'h32), 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    chki("t5 pre-reset beats", blog.size(), 1);
    chk_log("t5 pre", 0, DW'(8'h31), 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    blog.delete();
    idle(1, 1'b1);
    chk1("t5 in_ready after release 0", snap_ir[2], 1'b0);
    idle(1, 1'b1);
    chk1("t5 in_ready after release 1", snap_ir[2], 1'b0);
    idle(1, 1'b1);
    chk1("t5 in_ready after release 2", snap_ir[2], 1'b1);
    beat(DW'(8'h55), 1'b0, 1'b1);
    idle(2, 1'b1);
    chki("t5 beats", blog.size(), 1);
    chk_log("t5", 0, DW'(8'h55), 1'b1, 1'b1);

    // Scenario 6: random traffic, all latencies checked against the model.
    log_dut = 0;
    for (int i = 0; i < 1000; i++)
      step(1'b1, 1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom},
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           EW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
    idle(4, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
